rc4_prga_stream: RTL and testbench
==================================

Name: rc4_prga_stream

Overview:
- Parametrised RC4 keystream/decrypt engine; successor to the fixed 32-byte decrypter.
- Reads a length-prefixed ciphertext from the message ROM and runs PRGA over the initialised, key-scheduled S memory. Writes length-prefixed plaintext to result RAM.
- Optional printable-text check aborts early and reports validity, so the key-search controller can reject a key quickly.

Parameters:
- ADDR_WIDTH, 8: address width of msg, result and S memories.
- MAX_LEN, 32: largest accepted message length L; must be ≤ 2^ADDR_WIDTH − 1.
- CHECK_EN, 1: 1 = validate each plaintext byte and abort on failure; 0 = never abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- finish  out  1  high while in DONE
- valid  out  1  meaningful while finish=1; 1 = all bytes passed the check
- msg_addr  out  ADDR_WIDTH  ciphertext ROM address
- msg_q  in  8  ROM data; 1-cycle registered read
- result_addr  out  ADDR_WIDTH  plaintext RAM address
- result_data  out  8  plaintext RAM write data
- result_wren  out  1  plaintext RAM write enable
- s_addr  out  ADDR_WIDTH  S RAM address
- s_data  out  8  S RAM write data
- s_q  in  8  S RAM data; 1-cycle registered read, write-first
- s_wren  out  1  S RAM write enable

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On rst: state=IDLE; finish=0, valid=0, all wrens=0, all addr/data=0; i=j=k=0.
- Memory timing: all memory outputs are registered by the FSM. Read data is consumed two states after the address-driving state.
- Message format: msg[0]=L, msg[1..L]=ciphertext.
- Result format: result[0]=L, result[k]=plaintext byte for k=1..L.
- FSM, one cycle per state:
  - IDLE: on start → RD_LEN (msg_addr=0); clear i, j, k.
  - RD_LEN → WAIT_LEN → WR_LEN.
  - WR_LEN:
    - if L > MAX_LEN: no write, valid=0 → DONE.
    - otherwise: write result[0]=L.
      - L=0: valid=1 → DONE.
      - else k=1, valid=1 → INC_I.
  - Per byte (exactly 9 cycles):
    - INC_I: i=i+1 mod 256; s_addr=i.
    - WAIT_SI.
    - READ_SI: si=s_q; j=j+si mod 256; s_addr=j.
    - WAIT_SJ.
    - READ_SJ: sj=s_q; write S[j]=si.
    - WR_SI: write S[i]=sj.
    - RD_F: s_addr=si+sj mod 256; msg_addr=k.
    - WAIT_F.
    - XOR_WR: p=s_q XOR msg_q; write result[k]=p.
      - If CHECK_EN and p is not in {0x20, 0x61..0x7A}: valid=0 → DONE. The failing byte is still written.
      - Else if k==L → DONE; else k++ → INC_I.
  - DONE: finish=1, wrens=0. Start → RD_LEN (restart, fresh i=j=0); otherwise stay.
- When i==j, the swap writes the same location twice with the same value; S is unchanged. This is legal.
- Latency: finish rises exactly 4+9·L cycles after the edge that samples start (no abort, L ≤ MAX_LEN).
- At most one memory write per cycle; a wren is high for exactly one cycle per write.
- Start while busy is ignored. Reset mid-operation aborts immediately; partial writes are not undone.
- finish and valid change only on state transitions.

Decomposition:
- Package rc4_pkg:
  - state enum;
  - constants CHAR_SPACE=8'h20, CHAR_LO=8'h61, CHAR_HI=8'h7A;
  - function is_valid_char.
- One sub-module, rc4_char_check: combinational byte-range checker, so it can be reused by the key-search controller.

Test Plan:
- Reset then start with the known 32-byte ciphertext (L=32) and key-scheduled S → result[1..32] equals the reference plaintext; result[0]=32; valid=1; finish at cycle 4+288=292.
- L=0 → only result[0]=0 written; finish after 4 cycles; valid=1; no S writes.
- L=MAX_LEN+1 → no result writes; valid=0; finish after 4 cycles.
- CHECK_EN=1, ciphertext whose byte 3 decrypts to 0x41 → result[1..3] written, then valid=0, finish; result[4..] never written.
- Assert rst during byte 5, then start again with the same input and S re-initialised by the bench → output identical to a clean run.
- Pulse start during byte processing and hold start in DONE for one cycle → mid-run pulse ignored; the DONE start performs a second full run with i=j=0 reloaded.

Source files
------------

// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared types and helpers for the RC4 PRGA stream engine:
//                FSM state encoding and the printable-character predicate.
//  Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

    // One state per clock; the per-byte loop is INC_I .. XOR_WR (9 states)
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RD_LEN   = 4'd1,
        ST_WAIT_LEN = 4'd2,
        ST_WR_LEN   = 4'd3,
        ST_INC_I    = 4'd4,
        ST_WAIT_SI  = 4'd5,
        ST_READ_SI  = 4'd6,
        ST_WAIT_SJ  = 4'd7,
        ST_READ_SJ  = 4'd8,
        ST_WR_SI    = 4'd9,
        ST_RD_F     = 4'd10,
        ST_WAIT_F   = 4'd11,
        ST_XOR_WR   = 4'd12,
        ST_DONE     = 4'd13
    } rc4_state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;

    // Accepted plaintext alphabet: space and lowercase a..z
    function automatic logic is_valid_char(input logic [7:0] c);
        return (c == CHAR_SPACE) || ((c >= CHAR_LO) && (c <= CHAR_HI));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_prga_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_prga_stream_if
//  Description : Control handshake plus message ROM, result RAM and S RAM
//                buses of the RC4 PRGA stream engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rc4_prga_stream_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  finish;
    logic                  valid;
    logic [ADDR_WIDTH-1:0] msg_addr;
    logic [7:0]            msg_q;
    logic [ADDR_WIDTH-1:0] result_addr;
    logic [7:0]            result_data;
    logic                  result_wren;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [7:0]            s_data;
    logic [7:0]            s_q;
    logic                  s_wren;

    // Engine side
    modport master (
        input  start, msg_q, s_q,
        output finish, valid, msg_addr, result_addr, result_data, result_wren,
               s_addr, s_data, s_wren
    );

    // Controller / memory side
    modport slave (
        output start, msg_q, s_q,
        input  finish, valid, msg_addr, result_addr, result_data, result_wren,
               s_addr, s_data, s_wren
    );
endinterface
`default_nettype wire

// File: rtl/rc4_char_check.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_char_check
//  Description : Combinational plaintext byte checker (space or a..z).
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_char_check
    import rc4_pkg::*;
(
    input  wire logic [7:0] i_byte,
    output logic            o_valid
);

    // Pure range test, shared with the key-search controller
    assign o_valid = is_valid_char(i_byte);

endmodule
`default_nettype wire

// File: rtl/rc4_prga_stream.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_prga_stream
//  Description : RC4 PRGA decrypt engine. Reads a length-prefixed ciphertext,
//                runs PRGA over a key-scheduled S RAM and writes the
//                length-prefixed plaintext, optionally aborting on the first
//                non-printable byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_prga_stream
    import rc4_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_LEN    = 32,
    parameter int CHECK_EN   = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    rc4_prga_stream_if.master     bus
);

    localparam logic [7:0] c_max_len = 8'(MAX_LEN);

    rc4_state_t            r_state;
    logic [7:0]            r_i;
    logic [7:0]            r_j;
    logic [7:0]            r_k;
    logic [7:0]            r_len;
    logic [7:0]            r_si;
    logic [7:0]            r_sj;
    logic                  r_finish;
    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_msg_addr;
    logic [ADDR_WIDTH-1:0] r_res_addr;
    logic [7:0]            r_res_data;
    logic                  r_res_wren;
    logic [ADDR_WIDTH-1:0] r_s_addr;
    logic [7:0]            r_s_data;
    logic                  r_s_wren;

    logic [7:0]            w_p;
    logic                  w_p_ok;
    logic                  w_abort;
    logic [7:0]            w_j_next;

    // Plaintext byte is keystream XOR ciphertext, both arriving in XOR_WR
    assign w_p      = bus.s_q ^ bus.msg_q;
    assign w_abort  = (CHECK_EN != 0) && !w_p_ok;
    assign w_j_next = r_j + bus.s_q;

    rc4_char_check u_char_check (
        .i_byte  (w_p),
        .o_valid (w_p_ok)
    );

    // Sequencer: every memory address/data/enable is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_i        <= 8'd0;
            r_j        <= 8'd0;
            r_k        <= 8'd0;
            r_len      <= 8'd0;
            r_si       <= 8'd0;
            r_sj       <= 8'd0;
            r_finish   <= 1'b0;
            r_valid    <= 1'b0;
            r_msg_addr <= '0;
            r_res_addr <= '0;
            r_res_data <= 8'd0;
            r_res_wren <= 1'b0;
            r_s_addr   <= '0;
            r_s_data   <= 8'd0;
            r_s_wren   <= 1'b0;
        end else begin
            // Write enables are single-cycle pulses
            r_res_wren <= 1'b0;
            r_s_wren   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state    <= ST_RD_LEN;
                        r_i        <= 8'd0;
                        r_j        <= 8'd0;
                        r_k        <= 8'd0;
                        r_msg_addr <= '0;
                        r_finish   <= 1'b0;
                        r_valid    <= 1'b0;
                    end
                end
                ST_RD_LEN:   r_state <= ST_WAIT_LEN;
                ST_WAIT_LEN: r_state <= ST_WR_LEN;
                ST_WR_LEN: begin
                    if (bus.msg_q > c_max_len) begin
                        r_valid  <= 1'b0;
                        r_finish <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_len      <= bus.msg_q;
                        r_res_addr <= '0;
                        r_res_data <= bus.msg_q;
                        r_res_wren <= 1'b1;
                        r_valid    <= 1'b1;
                        if (bus.msg_q == 8'd0) begin
                            r_finish <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_k     <= 8'd1;
                            r_state <= ST_INC_I;
                        end
                    end
                end
                ST_INC_I: begin
                    r_i      <= r_i + 8'd1;
                    r_s_addr <= ADDR_WIDTH'(r_i + 8'd1);
                    r_state  <= ST_WAIT_SI;
                end
                ST_WAIT_SI: r_state <= ST_READ_SI;
                ST_READ_SI: begin
                    r_si     <= bus.s_q;
                    r_j      <= w_j_next;
                    r_s_addr <= ADDR_WIDTH'(w_j_next);
                    r_state  <= ST_WAIT_SJ;
                end
                ST_WAIT_SJ: r_state <= ST_READ_SJ;
                ST_READ_SJ: begin
                    r_sj     <= bus.s_q;
                    r_s_addr <= ADDR_WIDTH'(r_j);
                    r_s_data <= r_si;
                    r_s_wren <= 1'b1;
                    r_state  <= ST_WR_SI;
                end
                ST_WR_SI: begin
                    r_s_addr <= ADDR_WIDTH'(r_i);
                    r_s_data <= r_sj;
                    r_s_wren <= 1'b1;
                    r_state  <= ST_RD_F;
                end
                ST_RD_F: begin
                    r_s_addr   <= ADDR_WIDTH'(r_si + r_sj);
                    r_msg_addr <= ADDR_WIDTH'(r_k);
                    r_state    <= ST_WAIT_F;
                end
                ST_WAIT_F: r_state <= ST_XOR_WR;
                ST_XOR_WR: begin
                    // The failing byte is still written before aborting
                    r_res_addr <= ADDR_WIDTH'(r_k);
                    r_res_data <= w_p;
                    r_res_wren <= 1'b1;
                    if (w_abort) begin
                        r_valid  <= 1'b0;
                        r_finish <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (r_k == r_len) begin
                        r_finish <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_k     <= r_k + 8'd1;
                        r_state <= ST_INC_I;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.finish      = r_finish;
    assign bus.valid       = r_valid;
    assign bus.msg_addr    = r_msg_addr;
    assign bus.result_addr = r_res_addr;
    assign bus.result_data = r_res_data;
    assign bus.result_wren = r_res_wren;
    assign bus.s_addr      = r_s_addr;
    assign bus.s_data      = r_s_data;
    assign bus.s_wren      = r_s_wren;

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rc4_prga_stream
//  Description : Self-checking bench for rc4_prga_stream: behavioural ROM/RAMs,
//                reference RC4 model feeding a write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_prga_stream;

    localparam int AW      = 8;
    localparam int MAX_LEN = 32;
    localparam string TXT  = "the quick brown fox jumps over a";

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rc4_prga_stream_if #(.ADDR_WIDTH(AW)) bus ();

    rc4_prga_stream #(
        .ADDR_WIDTH (AW),
        .MAX_LEN    (MAX_LEN),
        .CHECK_EN   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] msg_mem [256];
    logic [7:0] s_mem   [256];
    logic [7:0] s_init  [256];
    logic [7:0] ms      [256];
    logic [7:0] key     [5] = '{8'h4B, 8'h65, 8'h79, 8'h21, 8'h07};
    logic       s_load;
    logic       sb_en;
    wr_t        exp_q[$];
    int         exp_n;
    logic       exp_valid;
    int         checks;
    int         failures;
    int         s_wr_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Registered-read ROM and write-first S RAM
    always @(posedge clk) begin
        bus.msg_q <= msg_mem[bus.msg_addr];
        if (s_load) begin
            for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
        end else if (bus.s_wren) begin
            s_mem[bus.s_addr] <= bus.s_data;
            bus.s_q           <= bus.s_data;
        end else begin
            bus.s_q <= s_mem[bus.s_addr];
        end
    end

    // Result-write monitor / scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.s_wren === 1'b1) s_wr_cnt++;
        if (sb_en && bus.result_wren === 1'b1) begin
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.result_addr), 32'(e.addr));
                chk("wr_data", 32'(bus.result_data), 32'(e.data));
            end
        end
    end

    task automatic ksa();
        int j = 0;
        logic [7:0] t;
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            j = (j + int'(s_init[n]) + int'(key[n % 5])) % 256;
            t = s_init[n]; s_init[n] = s_init[j]; s_init[j] = t;
        end
    endtask

    task automatic reload_s();
        s_load = 1'b1;
        @(posedge clk); #1;
        s_load = 1'b0;
        ms = s_init;
    endtask

    // Encrypt a plaintext with the keystream of the current model S
    task automatic load_msg(input string pt);
        logic [7:0] t [256];
        logic [7:0] x;
        int a = 0, b = 0;
        t = ms;
        msg_mem[0] = 8'(pt.len());
        for (int k = 1; k <= pt.len(); k++) begin
            a = (a + 1) % 256;
            b = (b + int'(t[a])) % 256;
            x = t[a]; t[a] = t[b]; t[b] = x;
            msg_mem[k] = pt[k-1] ^ t[(int'(t[a]) + int'(t[b])) % 256];
        end
    endtask

    // Reference PRGA: pushes expected result writes, advances model S
    task automatic model_run();
        int L, mi, mj;
        logic [7:0] t, p;
        L = int'(msg_mem[0]); mi = 0; mj = 0;
        exp_n = 0;
        if (L > MAX_LEN) begin
            exp_valid = 1'b0;
            return;
        end
        exp_valid = 1'b1;
        exp_q.push_back('{8'h00, 8'(L)});
        for (int k = 1; k <= L; k++) begin
            mi = (mi + 1) % 256;
            mj = (mj + int'(ms[mi])) % 256;
            t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
            p = msg_mem[k] ^ ms[(int'(ms[mi]) + int'(ms[mj])) % 256];
            exp_q.push_back('{8'(k), p});
            exp_n = k;
            if (!(p == 8'h20 || (p >= 8'h61 && p <= 8'h7A))) begin
                exp_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic launch();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Cycle 1 is the RD_LEN cycle entered at the start-sampling edge
    task automatic run(input string tag, input int pulse_at);
        int n, s0, diff;
        s0 = s_wr_cnt;
        launch();
        n = 1;
        while (!bus.finish && n < 4000) begin
            bus.start = (n == pulse_at);
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        chk({tag, "_finish"}, 32'(bus.finish), 32'd1);
        chk({tag, "_cycle"}, n, 4 + 9 * exp_n);
        chk({tag, "_valid"}, 32'(bus.valid), 32'(exp_valid));
        repeat (2) begin @(posedge clk); #1; end
        chk({tag, "_finish_hold"}, 32'(bus.finish), 32'd1);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        chk({tag, "_s_writes"}, s_wr_cnt - s0, 2 * exp_n);
        diff = 0;
        for (int m = 0; m < 256; m++) if (s_mem[m] !== ms[m]) diff++;
        chk({tag, "_s_final"}, diff, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctrl"}, 32'({bus.finish, bus.valid, bus.result_wren, bus.s_wren}), 32'd0);
        chk({tag, "_addr"}, 32'({bus.msg_addr, bus.result_addr, bus.s_addr}), 32'd0);
        chk({tag, "_data"}, 32'({bus.result_data, bus.s_data}), 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        sb_en = 1'b1; s_load = 1'b0; bus.start = 1'b0; rst = 1'b1;
        for (int n = 0; n < 256; n++) msg_mem[n] = 8'h00;
        ksa();
        ms = s_init;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;

        reload_s(); load_msg(TXT); model_run(); run("ref32", 0);
        reload_s(); msg_mem[0] = 8'd0; model_run(); run("len0", 0);
        reload_s(); msg_mem[0] = 8'(MAX_LEN + 1); model_run(); run("len_over", 0);
        reload_s(); load_msg("abAdefgh"); model_run(); run("abort3", 0);

        // Reset in the middle of byte 5, then a clean rerun
        reload_s(); load_msg(TXT);
        sb_en = 1'b0;
        launch();
        repeat (41) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset("mid_reset");
        rst = 1'b0;
        sb_en = 1'b1;
        reload_s(); model_run(); run("after_rst", 0);

        // Start pulse while busy is ignored; start held in DONE restarts
        reload_s(); model_run(); run("busy_pulse", 20);
        model_run(); run("done_restart", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
